aes_vector_sequencer: RTL and testbench

AES_VECTOR_SEQUENCER -- requirements
Module: aes_vector_sequencer

---
 rtl/aes_vector_sequencer.sv | 167 ++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer.sv
// Replays stored plaintext/key pairs to an AES core at a fixed cadence and
// fires a scope trigger for every vector the core accepts.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no run active; vector memory writable; start accepted here
// ST_WAIT  | counting PERIOD cycles before presenting the next vector
// ST_ISSUE | vector presented with vec_valid high, waiting for vec_ready
module aes_vector_sequencer #(
   parameter int DATA_W   = 128,
   parameter int KEY_W    = 128,
   parameter int DEPTH    = 8,
   parameter int PERIOD   = 400,
   parameter int TRIG_LEN = 4,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [IDX_W:0]    num_vec,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [KEY_W-1:0]  wr_key,
   output logic [DATA_W-1:0] data_out,
   output logic [KEY_W-1:0]  key_out,
   output logic              vec_valid,
   input  logic              vec_ready,
   output logic              trig,
   output logic              busy,
   output logic              done,
   output logic [31:0]       issued_cnt
);

   localparam int NV_W  = IDX_W + 1;
   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TL_W  = $clog2(TRIG_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [DATA_W+KEY_W-1:0]   mem [DEPTH];
   logic [NV_W-1:0]           num_vec_q;
   logic                      loop_q;
   logic [IDX_W-1:0]          idx_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [TL_W-1:0]           trig_cnt;
   logic                      start_ok;
   logic                      last_vec;
   logic                      accept;
   logic                      load_vec;
   logic                      hs;
   logic                      finish;

   assign start_ok = start && (num_vec != '0) && (num_vec <= NV_W'(DEPTH));
   assign last_vec = ({1'b0, idx_q} == (num_vec_q - NV_W'(1)));
   assign busy     = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      load_vec = 1'b0;
      hs       = 1'b0;
      finish   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(PERIOD - 1)) begin
               load_vec = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // stop takes priority over a handshake in the same cycle
            if (stop) begin
               state_d = ST_IDLE;
            end else if (vec_valid && vec_ready) begin
               hs = 1'b1;
               if (last_vec && !loop_q) begin
                  finish  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Vector memory has no reset so its contents survive an aborted run.
   always_ff @(posedge clk) begin
      if (wr_en && (state_q == ST_IDLE)) begin
         mem[wr_addr] <= {wr_data, wr_key};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_vec_q  <= '0;
         loop_q     <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
         data_out   <= '0;
         key_out    <= '0;
         vec_valid  <= 1'b0;
         issued_cnt <= '0;
         done       <= 1'b0;
         trig       <= 1'b0;
         trig_cnt   <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            num_vec_q <= num_vec;
            loop_q    <= loop_mode;
            idx_q     <= '0;
            cnt_q     <= '0;
         end
         if ((state_q == ST_WAIT) && !stop) begin
            cnt_q <= load_vec ? '0 : cnt_q + CNT_W'(1);
         end
         if (load_vec) begin
            {data_out, key_out} <= mem[idx_q];
            vec_valid           <= 1'b1;
         end
         if (hs) begin
            vec_valid  <= 1'b0;
            issued_cnt <= issued_cnt + 32'd1;
            idx_q      <= last_vec ? '0 : idx_q + IDX_W'(1);
         end
         if (stop && (state_q != ST_IDLE)) begin
            vec_valid <= 1'b0;
         end
         // Trigger runs on its own so a pulse always completes its full width.
         if (hs) begin
            trig     <= 1'b1;
            trig_cnt <= TL_W'(TRIG_LEN - 1);
         end else if (trig_cnt != '0) begin
            trig_cnt <= trig_cnt - TL_W'(1);
         end else begin
            trig <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Scoreboard bench for aes_vector_sequencer: a stimulus process plans each run
// from a shadow memory, and a monitor checks vectors, cadence, trig and done.
module tb_aes_vector_sequencer;

   localparam int DATA_W   = 128;
   localparam int KEY_W    = 128;
   localparam int DEPTH    = 8;
   localparam int PERIOD   = 400;
   localparam int TRIG_LEN = 4;
   localparam int IDX_W    = $clog2(DEPTH);
   localparam int NV_W     = IDX_W + 1;

   logic              clk       = 1'b0;
   logic              reset     = 1'b1;
   logic              start     = 1'b0;
   logic              stop      = 1'b0;
   logic              loop_mode = 1'b0;
   logic [NV_W-1:0]   num_vec   = '0;
   logic              wr_en     = 1'b0;
   logic [IDX_W-1:0]  wr_addr   = '0;
   logic [DATA_W-1:0] wr_data   = '0;
   logic [KEY_W-1:0]  wr_key    = '0;
   logic              vec_ready = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic [KEY_W-1:0]  key_out;
   logic              vec_valid;
   logic              trig;
   logic              busy;
   logic              done;
   logic [31:0]       issued_cnt;

   aes_vector_sequencer #(
      .DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH),
      .PERIOD(PERIOD), .TRIG_LEN(TRIG_LEN)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .loop_mode(loop_mode), .num_vec(num_vec), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_key(wr_key),
      .data_out(data_out), .key_out(key_out), .vec_valid(vec_valid),
      .vec_ready(vec_ready), .trig(trig), .busy(busy), .done(done),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [KEY_W-1:0]  k;
      bit                fin;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] m_data [DEPTH];
   logic [KEY_W-1:0]  m_key  [DEPTH];
   int                n_pass = 0;
   int                n_total = 0;
   int                cyc = 0;
   int                anchor_edge = 0;
   bit                anchor_valid = 1'b0;
   bit                running = 1'b0;
   bit                rdy_rand = 1'b0;
   int                tb_issued = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_write(input int addr, input logic [127:0] d, input logic [127:0] k);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(addr);
      wr_data = d;
      wr_key  = k;
      if (!running) begin
         m_data[addr] = d;
         m_key[addr]  = k;
      end
      tick();
      wr_en = 1'b0;
   endtask

   // Plans n_iss handshakes for a run: the i-th issue is entry i mod nv.
   task automatic do_start(input int nv, input bit lp, input int n_iss,
                           input bit w, input int waddr, input bit also_stop);
      logic [127:0] d;
      logic [127:0] k;
      if (w) begin
         d = rnd128();
         k = rnd128();
         wr_en = 1'b1; wr_addr = IDX_W'(waddr); wr_data = d; wr_key = k;
         m_data[waddr] = d;
         m_key[waddr]  = k;
      end
      for (int i = 0; i < n_iss; i++) begin
         exp_t e;
         e.d   = m_data[i % nv];
         e.k   = m_key[i % nv];
         e.fin = !lp && (i == nv - 1);
         exp_q.push_back(e);
      end
      start = 1'b1; num_vec = NV_W'(nv); loop_mode = lp; stop = also_stop;
      tick();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      anchor_edge  = cyc;
      anchor_valid = 1'b1;
      running      = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin tick(); n++; end
      chk({name, "_idle_in_time"}, busy, 0);
      running = 1'b0;
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      while (!vec_valid && n < budget) begin tick(); n++; end
      chk({name, "_valid_in_time"}, vec_valid, 1);
   endtask

   task automatic wait_issued(input int target, input int budget, input string name);
      int n = 0;
      while (issued_cnt != 32'(target) && n < budget) begin tick(); n++; end
      chk({name, "_issued_in_time"}, issued_cnt, target);
   endtask

   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #2;
         if (rdy_rand) vec_ready = ($urandom_range(0, 3) == 0);
      end
   end

   initial begin : monitor
      exp_t              cur;
      logic [DATA_W-1:0] last_d;
      logic [KEY_W-1:0]  last_k;
      int                rem;
      int                model_iss;
      bit                done_exp;
      bit                post_hs;
      bit                prev_valid;
      bit                hs_now;
      cur.d = '0; cur.k = '0; cur.fin = 1'b0;
      last_d = '0; last_k = '0; rem = 0; model_iss = 0;
      done_exp = 1'b0; post_hs = 1'b0; prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            cur.fin = 1'b0; last_d = '0; last_k = '0; rem = 0; model_iss = 0;
            done_exp = 1'b0; post_hs = 1'b0; prev_valid = 1'b0; anchor_valid = 1'b0;
            continue;
         end
         if (vec_valid && !prev_valid) begin
            chk("vector_expected", 128'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               cur    = exp_q.pop_front();
               last_d = cur.d;
               last_k = cur.k;
            end
            if (anchor_valid) chk("issue_spacing", 128'(cyc - anchor_edge), PERIOD);
         end
         chk("data_out", data_out, last_d);
         chk("key_out", key_out, last_k);
         chk("trig", trig, 128'(rem > 0));
         chk("issued_cnt", issued_cnt, 128'(model_iss));
         chk("done", done, 128'(done_exp));
         if (post_hs) chk("valid_drop", vec_valid, 0);
         prev_valid = vec_valid;
         hs_now     = vec_valid && vec_ready && !stop;
         if (rem > 0) rem--;
         done_exp = 1'b0;
         post_hs  = hs_now;
         if (hs_now) begin
            rem          = TRIG_LEN;
            model_iss++;
            done_exp     = cur.fin;
            anchor_edge  = cyc + 1;
            anchor_valid = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #(60000 * 10);
      $display("FAIL watchdog: run exceeded 60000 cycles, got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_data_out", data_out, 0);
      chk("rst_key_out", key_out, 0);
      chk("rst_vec_valid", vec_valid, 0);
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_issued_cnt", issued_cnt, 0);
      reset = 1'b1;
      tick();

      // single pass over four vectors, core always ready
      vec_ready = 1'b1;
      do_write(0, 128'h205B_7A3E_91C4_D026_8F1B_44E2_93A0_55C7,
                  128'h5C9D_31F2_0AB8_6E47_C13D_9925_7F60_E807);
      for (int a = 1; a < 4; a++) do_write(a, rnd128(), rnd128());
      do_start(4, 1'b0, 4, 1'b0, 0, 1'b0);
      wait_idle(4 * (PERIOD + 5) + 10, "t1");
      tb_issued = 4;
      chk("t1_issued", issued_cnt, tb_issued);

      // looping over three vectors, stopped while trig is still high
      for (int a = 0; a < 3; a++) do_write(a, rnd128(), rnd128());
      do_start(3, 1'b1, 7, 1'b0, 0, 1'b0);
      wait_issued(tb_issued + 7, 7 * (PERIOD + 5) + 10, "t2");
      tb_issued += 7;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      running = 1'b0;
      chk("t2_stop_idle", busy, 0);
      chk("t2_trig_continues", trig, 1);
      repeat (6) tick();
      chk("t2_issued", issued_cnt, tb_issued);

      // core stalls 50 cycles with the vector held
      vec_ready = 1'b0;
      do_start(2, 1'b0, 2, 1'b0, 0, 1'b0);
      wait_valid(PERIOD + 10, "t3a");
      repeat (50) begin
         tick();
         chk("t3_hold_valid", vec_valid, 1);
      end
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      chk("t3_trig_after_ready", trig, 1);
      chk("t3_valid_low", vec_valid, 0);
      wait_valid(PERIOD + 10, "t3b");
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      wait_idle(10, "t3");
      tb_issued += 2;
      chk("t3_issued", issued_cnt, tb_issued);

      // write attempted mid-run is dropped; bad num_vec starts are ignored
      vec_ready = 1'b1;
      do_start(2, 1'b0, 2, 1'b0, 0, 1'b0);
      repeat (5) tick();
      do_write(1, rnd128(), rnd128());
      wait_idle(2 * (PERIOD + 5) + 10, "t4");
      tb_issued += 2;
      chk("t4_issued", issued_cnt, tb_issued);
      num_vec = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_nv0_idle", busy, 0);
      num_vec = NV_W'(DEPTH + 1); start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_nv_over_idle", busy, 0);
      repeat (3) tick();
      chk("t4_still_idle", busy, 0);

      // asynchronous reset while a vector is being presented
      vec_ready = 1'b0;
      do_start(3, 1'b0, 3, 1'b0, 0, 1'b0);
      wait_valid(PERIOD + 10, "t5");
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("t5_data_out", data_out, 0);
      chk("t5_key_out", key_out, 0);
      chk("t5_vec_valid", vec_valid, 0);
      chk("t5_trig", trig, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_issued_cnt", issued_cnt, 0);
      exp_q.delete();
      running = 1'b0;
      tb_issued = 0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      vec_ready = 1'b1;
      for (int a = 0; a < 2; a++) do_write(a, rnd128(), rnd128());
      do_start(2, 1'b0, 2, 1'b0, 0, 1'b0);
      wait_idle(2 * (PERIOD + 5) + 10, "t5b");
      tb_issued = 2;
      chk("t5_issued_after", issued_cnt, tb_issued);

      // stop in the same cycle as the handshake
      vec_ready = 1'b0;
      do_start(2, 1'b1, 1, 1'b0, 0, 1'b0);
      wait_valid(PERIOD + 10, "t6");
      repeat (2) tick();
      vec_ready = 1'b1; stop = 1'b1;
      tick();
      vec_ready = 1'b0; stop = 1'b0;
      running = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_vec_valid", vec_valid, 0);
      chk("t6_trig", trig, 0);
      chk("t6_issued", issued_cnt, tb_issued);
      repeat (3) tick();
      chk("t6_no_trig", trig, 0);

      // random single passes with a random core, same-cycle write on start
      rdy_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         int nv;
         nv = $urandom_range(1, DEPTH);
         for (int a = 0; a < DEPTH; a++) do_write(a, rnd128(), rnd128());
         do_start(nv, 1'b0, nv, 1'b1, $urandom_range(0, nv - 1), r == 1);
         wait_idle(nv * (PERIOD + 120) + 20, "t7");
         tb_issued += nv;
         chk("t7_issued", issued_cnt, tb_issued);
      end
      rdy_rand = 1'b0;

      repeat (5) tick();
      chk("queue_drained", 128'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
